// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU controller and its datapath:
// opcodes, FSM states and the mux-select codes driven into the datapath.
package multicycle_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_LWD = 2'b01,
        OP_SWD = 2'b10,
        OP_JMP = 2'b11
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    localparam logic [1:0] PC_SRC_ALU  = 2'b00;
    localparam logic [1:0] PC_SRC_JUMP = 2'b01;

    localparam logic [1:0] ALU_B_RT   = 2'b00;
    localparam logic [1:0] ALU_B_ONE  = 2'b01;
    localparam logic [1:0] ALU_B_SEXT = 2'b10;

    function automatic logic is_mem_op(input logic [1:0] op);
        return (op == OP_LWD) || (op == OP_SWD);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles spent waiting for mem_ack and flags the cycle in
// which the wait would reach MEM_TIMEOUT. MEM_TIMEOUT = 0 disables the flag.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    // The current wait cycle is the one that would make the count hit the limit;
    // an ack in that same cycle deasserts inc and therefore wins.
    assign expired = (MEM_TIMEOUT != 0) && inc && (count == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the 8-bit CPU: sequences fetch/decode/execute/
// mem/writeback, drives datapath selects/strobes, counts retired instructions.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       opcode,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             alu_a_sel,
    output logic [1:0]       alu_b_sel,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic [CNT_W-1:0] num_inst,
    output logic             timeout_err
);

    state_t state;
    state_t state_next;
    logic   retire;
    logic   wait_inc;
    logic   expired;

    // Kept outside the FSM process so the timer's expired flag does not loop back.
    assign wait_inc = ((state == ST_FETCH) || (state == ST_MEM)) && !mem_ack;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (!wait_inc),
        .inc     (wait_inc),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            num_inst    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_next;
            if (retire) begin
                num_inst <= num_inst + 1'b1;
            end
            if (expired) begin
                timeout_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_ALU;
        alu_a_sel  = 1'b0;
        alu_b_sel  = ALU_B_RT;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        retire     = 1'b0;
        case (state)
            ST_IDLE: state_next = ST_FETCH;
            ST_FETCH: begin
                // ALU computes PC+1 while the instruction word is being read.
                mem_req   = 1'b1;
                alu_b_sel = ALU_B_ONE;
                if (mem_ack) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = ST_DECODE;
                end else if (expired) begin
                    state_next = ST_HALT;
                end
            end
            ST_DECODE: begin
                if (opcode == OP_JMP) begin
                    pc_write   = 1'b1;
                    pc_src     = PC_SRC_JUMP;
                    retire     = 1'b1;
                    state_next = ST_FETCH;
                end else begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_a_sel = 1'b1;
                if (is_mem_op(opcode)) begin
                    alu_b_sel  = ALU_B_SEXT;
                    state_next = ST_MEM;
                end else begin
                    state_next = ST_WB;
                end
            end
            ST_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = (opcode == OP_SWD);
                if (mem_ack) begin
                    if (opcode == OP_SWD) begin
                        retire     = 1'b1;
                        state_next = ST_FETCH;
                    end else begin
                        state_next = ST_WB;
                    end
                end else if (expired) begin
                    state_next = ST_HALT;
                end
            end
            ST_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (opcode == OP_ADD);
                mem_to_reg = (opcode == OP_LWD);
                retire     = 1'b1;
                state_next = ST_FETCH;
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl (CNT_W=4, MEM_TIMEOUT=4): walks each
// instruction class cycle by cycle against hand-computed strobe vectors.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] opcode = 2'b00;
    logic       mem_ack = 1'b0;
    logic       mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0] pc_src, alu_b_sel;
    logic       alu_a_sel, reg_write, reg_dst, mem_to_reg;
    logic [3:0] num_inst;
    logic       timeout_err;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    multicycle_ctrl #(.CNT_W(4), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .alu_a_sel(alu_a_sel),
        .alu_b_sel(alu_b_sel), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .num_inst(num_inst), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_a_sel, alu_b_sel, reg_write, reg_dst, mem_to_reg}
    logic [12:0] outv;
    assign outv = {mem_req, mem_we, iord, ir_write, pc_write, pc_src,
                   alu_a_sel, alu_b_sel, reg_write, reg_dst, mem_to_reg};

    localparam logic [12:0] V_ZERO    = 13'b0_0_0_0_0_00_0_00_0_0_0;
    localparam logic [12:0] V_FETCH_W = 13'b1_0_0_0_0_00_0_01_0_0_0;
    localparam logic [12:0] V_FETCH_A = 13'b1_0_0_1_1_00_0_01_0_0_0;
    localparam logic [12:0] V_DEC_JMP = 13'b0_0_0_0_1_01_0_00_0_0_0;
    localparam logic [12:0] V_EX_ADD  = 13'b0_0_0_0_0_00_1_00_0_0_0;
    localparam logic [12:0] V_EX_LS   = 13'b0_0_0_0_0_00_1_10_0_0_0;
    localparam logic [12:0] V_MEM_LWD = 13'b1_0_1_0_0_00_0_00_0_0_0;
    localparam logic [12:0] V_MEM_SWD = 13'b1_1_1_0_0_00_0_00_0_0_0;
    localparam logic [12:0] V_WB_ADD  = 13'b0_0_0_0_0_00_0_00_1_1_0;
    localparam logic [12:0] V_WB_LWD  = 13'b0_0_0_0_0_00_0_00_1_0_1;

    localparam logic [1:0] ADD = 2'b00, LWD = 2'b01, SWD = 2'b10, JMP = 2'b11;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) begin
            passed++;
            $display("check %-12s observed %h expected %h ok", tag, got, exp);
        end else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs just after the edge, then check the decoded outputs.
    task automatic cyc(input logic ack, input logic [1:0] op, input logic [12:0] exp, input string tag);
        @(posedge clk);
        #1;
        mem_ack = ack;
        opcode  = op;
        #1;
        chk(tag, {3'b000, outv}, {3'b000, exp});
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_out", {3'b000, outv}, {3'b000, V_ZERO});
        chk("rst_num", {12'd0, num_inst}, 16'd0);
        chk("rst_terr", {15'd0, timeout_err}, 16'd0);
        reset_n = 1'b1;
        #1;
        chk("idle_out", {3'b000, outv}, {3'b000, V_ZERO});

        // ADD 8'h1B, zero-wait memory
        cyc(1'b1, ADD, V_FETCH_A, "add_fetch");
        cyc(1'b0, ADD, V_ZERO,    "add_dec");
        cyc(1'b0, ADD, V_EX_ADD,  "add_exec");
        cyc(1'b0, ADD, V_WB_ADD,  "add_wb");
        chk("add_num_pre", {12'd0, num_inst}, 16'd0);

        // LWD 8'h43, three wait cycles in MEM
        cyc(1'b1, LWD, V_FETCH_A, "lwd_fetch");
        chk("add_num", {12'd0, num_inst}, 16'd1);
        cyc(1'b0, LWD, V_ZERO,    "lwd_dec");
        cyc(1'b0, LWD, V_EX_LS,   "lwd_exec");
        cyc(1'b0, LWD, V_MEM_LWD, "lwd_mem_w1");
        cyc(1'b0, LWD, V_MEM_LWD, "lwd_mem_w2");
        cyc(1'b0, LWD, V_MEM_LWD, "lwd_mem_w3");
        cyc(1'b1, LWD, V_MEM_LWD, "lwd_mem_ack");
        cyc(1'b0, LWD, V_WB_LWD,  "lwd_wb");

        // SWD 8'h85 followed by JMP 8'hC5
        cyc(1'b1, SWD, V_FETCH_A, "swd_fetch");
        chk("lwd_num", {12'd0, num_inst}, 16'd2);
        cyc(1'b0, SWD, V_ZERO,    "swd_dec");
        cyc(1'b0, SWD, V_EX_LS,   "swd_exec");
        cyc(1'b1, SWD, V_MEM_SWD, "swd_mem");
        cyc(1'b1, JMP, V_FETCH_A, "jmp_fetch");
        chk("swd_num", {12'd0, num_inst}, 16'd3);
        cyc(1'b0, JMP, V_DEC_JMP, "jmp_dec");

        // Ack arrives in the 4th FETCH cycle: exactly at the limit, no error
        cyc(1'b0, ADD, V_FETCH_W, "lim_w1");
        chk("jmp_num", {12'd0, num_inst}, 16'd4);
        cyc(1'b0, ADD, V_FETCH_W, "lim_w2");
        cyc(1'b0, ADD, V_FETCH_W, "lim_w3");
        cyc(1'b1, ADD, V_FETCH_A, "lim_ack");
        cyc(1'b0, ADD, V_ZERO,    "lim_dec");
        chk("lim_terr", {15'd0, timeout_err}, 16'd0);
        cyc(1'b0, ADD, V_EX_ADD,  "lim_exec");
        cyc(1'b0, ADD, V_WB_ADD,  "lim_wb");

        // SWD interrupted by reset while waiting in MEM
        cyc(1'b1, SWD, V_FETCH_A, "rs_fetch");
        chk("lim_num", {12'd0, num_inst}, 16'd5);
        cyc(1'b0, SWD, V_ZERO,    "rs_dec");
        cyc(1'b0, SWD, V_EX_LS,   "rs_exec");
        cyc(1'b0, SWD, V_MEM_SWD, "rs_mem");
        #1;
        reset_n = 1'b0;
        #1;
        chk("rs_async_out", {3'b000, outv}, {3'b000, V_ZERO});
        chk("rs_async_num", {12'd0, num_inst}, 16'd0);
        @(posedge clk);
        #1;
        chk("rs_hold_out", {3'b000, outv}, {3'b000, V_ZERO});
        mem_ack = 1'b0;
        reset_n = 1'b1;
        #1;
        chk("rs_idle_out", {3'b000, outv}, {3'b000, V_ZERO});

        // 17 ADDs: counter wraps 15 -> 0 -> 1
        for (int i = 0; i < 17; i++) begin
            cyc(1'b1, ADD, V_FETCH_A, "wrap_fetch");
            chk("wrap_num", {12'd0, num_inst}, 16'(i % 16));
            cyc(1'b0, ADD, V_ZERO,   "wrap_dec");
            cyc(1'b0, ADD, V_EX_ADD, "wrap_exec");
            cyc(1'b0, ADD, V_WB_ADD, "wrap_wb");
        end

        // No ack in FETCH: timeout after the 4th wait cycle, then HALT
        cyc(1'b0, ADD, V_FETCH_W, "to_w1");
        chk("wrap_num_end", {12'd0, num_inst}, 16'd1);
        cyc(1'b0, ADD, V_FETCH_W, "to_w2");
        cyc(1'b0, ADD, V_FETCH_W, "to_w3");
        cyc(1'b0, ADD, V_FETCH_W, "to_w4");
        chk("to_terr_pre", {15'd0, timeout_err}, 16'd0);
        cyc(1'b0, ADD, V_ZERO,    "to_halt");
        chk("to_terr", {15'd0, timeout_err}, 16'd1);
        chk("to_req", {15'd0, mem_req}, 16'd0);
        cyc(1'b1, ADD, V_ZERO,    "to_halt_ack");
        cyc(1'b0, ADD, V_ZERO,    "to_halt_hold");
        chk("to_num", {12'd0, num_inst}, 16'd1);
        chk("to_terr_hold", {15'd0, timeout_err}, 16'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
